// File: rtl/seq_det_ctrl.sv
// Programmable Mealy serial pattern detector, sequenced over a bounded window of valid bits.
// A host starts a session with a latched pattern config and receives a done pulse plus a match count.
module seq_det_ctrl #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_ovl,
  input  logic [CNT_W-1:0] cfg_win,
  input  logic             in_valid,
  input  logic             in_seq,
  output logic             det_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam int unsigned WIN_W  = PAT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_nxt;
  logic [PAT_W-1:0]   pat_q, pat_nxt;
  logic [3:0]         len_q, len_nxt;
  logic               ovl_q, ovl_nxt;
  logic [CNT_W-1:0]   win_q, win_nxt;
  logic [PAT_W-1:0]   hist_q, hist_nxt;
  logic [FILL_W-1:0]  fill_q, fill_nxt;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_nxt;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;

  logic               cfg_bad_c;
  logic [WIN_W-1:0]   win_bits_c;
  logic [WIN_W-1:0]   mask_c;
  logic               hit_c;
  logic               det_c;

  // Match compare over the newest len bits, including the bit arriving this cycle
  always_comb begin
    cfg_bad_c  = (cfg_len == 4'd0) || (32'(cfg_len) > PAT_W) || (cfg_win == '0);
    win_bits_c = {hist_q, in_seq};
    mask_c     = WIN_W'((32'd1 << len_q) - 32'd1);
    hit_c      = ((32'(fill_q) + 32'd1) >= 32'(len_q)) &&
                 (((win_bits_c ^ {1'b0, pat_q}) & mask_c) == '0);
    det_c      = (state_q == S_RUN) && in_valid && hit_c;
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt     = state_q;
    pat_nxt       = pat_q;
    len_nxt       = len_q;
    ovl_nxt       = ovl_q;
    win_nxt       = win_q;
    hist_nxt      = hist_q;
    fill_nxt      = fill_q;
    bit_cnt_nxt   = bit_cnt_q;
    match_cnt_nxt = match_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_nxt       = cfg_pat;
          len_nxt       = cfg_len;
          ovl_nxt       = cfg_ovl;
          win_nxt       = cfg_win;
          hist_nxt      = '0;
          fill_nxt      = '0;
          bit_cnt_nxt   = '0;
          match_cnt_nxt = '0;
          state_nxt     = cfg_bad_c ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          hist_nxt    = {hist_q[PAT_W-2:0], in_seq};
          bit_cnt_nxt = bit_cnt_q + CNT_W'(1);
          if (hit_c && !ovl_q) begin
            fill_nxt = '0;
          end else if (fill_q != FILL_W'(PAT_W)) begin
            fill_nxt = fill_q + FILL_W'(1);
          end
          if (hit_c && (match_cnt_q != '1)) begin
            match_cnt_nxt = match_cnt_q + CNT_W'(1);
          end
          if ((bit_cnt_q + CNT_W'(1)) == win_q) begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt == S_RUN);
    done_nxt = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      win_q       <= '0;
      hist_q      <= '0;
      fill_q      <= '0;
      bit_cnt_q   <= '0;
      match_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pat_q       <= pat_nxt;
      len_q       <= len_nxt;
      ovl_q       <= ovl_nxt;
      win_q       <= win_nxt;
      hist_q      <= hist_nxt;
      fill_q      <= fill_nxt;
      bit_cnt_q   <= bit_cnt_nxt;
      match_cnt_q <= match_cnt_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
    end
  end

  assign det_out   = det_c;
  assign busy      = busy_q;
  assign done      = done_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: overlap/non-overlap detection, valid gaps, invalid configs,
// mid-session reset and a narrow-counter instance.
module tb_seq_det_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       cfg_ovl;
  logic [7:0] cfg_win;
  logic       in_valid;
  logic       in_seq;
  logic       det_out;
  logic       busy;
  logic       done;
  logic [7:0] match_cnt;

  logic       start4;
  logic [3:0] win4;
  logic       valid4;
  logic       seq4;
  logic       det4;
  logic       busy4;
  logic       done4;
  logic [3:0] cnt4;

  int passed;
  int total;

  seq_det_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_ovl(cfg_ovl), .cfg_win(cfg_win), .in_valid(in_valid), .in_seq(in_seq),
    .det_out(det_out), .busy(busy), .done(done), .match_cnt(match_cnt)
  );

  seq_det_ctrl #(.PAT_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_ovl(cfg_ovl), .cfg_win(win4), .in_valid(valid4), .in_seq(seq4),
    .det_out(det4), .busy(busy4), .done(done4), .match_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at posedge+1 in an IDLE cycle; returns at posedge+1 of the cycle after start.
  // The config inputs are scrambled afterwards so a session must run on its latched copy.
  task automatic start_session(input logic [7:0] p, input logic [3:0] l, input logic o,
                               input logic [7:0] w);
    cfg_pat = p; cfg_len = l; cfg_ovl = o; cfg_win = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cfg_pat = ~p; cfg_len = l + 4'd2; cfg_ovl = ~o; cfg_win = w + 8'd3;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'($urandom); cfg_pat = 8'($urandom); cfg_len = 4'($urandom);
    cfg_ovl = 1'($urandom); cfg_win = 8'($urandom); in_valid = 1'b1; in_seq = 1'($urandom);
    start4 = 1'($urandom); win4 = 4'($urandom); valid4 = 1'b1; seq4 = 1'($urandom);
    #12;
    total++; if ({det_out, busy, done, match_cnt} !== 11'd0)
      $display("FAIL reset_outs: got det=%b busy=%b done=%b cnt=%0d want all 0", det_out, busy, done, match_cnt);
    else passed++;
    total++; if ({det4, busy4, done4, cnt4} !== 7'd0)
      $display("FAIL reset_outs4: got det=%b busy=%b done=%b cnt=%0d want all 0", det4, busy4, done4, cnt4);
    else passed++;
    start = 1'b0; in_valid = 1'b0; in_seq = 1'b0; start4 = 1'b0; valid4 = 1'b0; seq4 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if ({busy, done, match_cnt} !== 10'd0)
      $display("FAIL reset_idle: got busy=%b done=%b cnt=%0d want 0 0 0", busy, done, match_cnt);
    else passed++;
  endtask

  // Stream 1,0,1,0,1 against pattern 101; exp_det lists det_out per bit, first bit at index 4.
  task automatic run_101(input string name, input logic ovl, input logic [4:0] exp_det,
                         input logic [7:0] exp_cnt, input int gaps);
    logic [4:0] stream;
    stream = 5'b10101;
    start_session(8'b0000_0101, 4'd3, ovl, 8'd5);
    total++; if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL %s_busy: got busy=%b done=%b want 1 0", name, busy, done);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gaps; g++) begin
          in_valid = 1'b0; in_seq = 1'(g + i);
          #1;
          total++; if (det_out !== 1'b0 || busy !== 1'b1)
            $display("FAIL %s_gap%0d: got det=%b busy=%b want 0 1", name, i, det_out, busy);
          else passed++;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1; in_seq = stream[4-i];
      #1;
      total++; if (det_out !== exp_det[4-i])
        $display("FAIL %s_det bit%0d: got %b want %b", name, i + 1, det_out, exp_det[4-i]);
      else passed++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i == 2) begin
        total++; if (match_cnt !== 8'd1)
          $display("FAIL %s_cnt_bit3: got %0d want 1", name, match_cnt);
        else passed++;
      end
    end
    total++; if (done !== 1'b1 || busy !== 1'b0 || match_cnt !== exp_cnt)
      $display("FAIL %s_done: got done=%b busy=%b cnt=%0d want 1 0 %0d", name, done, busy, match_cnt, exp_cnt);
    else passed++;
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0 || match_cnt !== exp_cnt)
      $display("FAIL %s_idle: got done=%b busy=%b cnt=%0d want 0 0 %0d", name, done, busy, match_cnt, exp_cnt);
    else passed++;
  endtask

  task automatic test_overlap();
    run_101("ovl", 1'b1, 5'b00101, 8'd2, 0);
  endtask

  // Starts in the IDLE cycle right after the previous session's done: back-to-back acceptance.
  task automatic test_back_to_back();
    run_101("novl", 1'b0, 5'b00100, 8'd1, 0);
  endtask

  task automatic test_gaps();
    run_101("gaps", 1'b1, 5'b00101, 8'd2, 2);
  endtask

  task automatic test_invalid();
    logic [3:0] lens [3];
    logic [7:0] wins [3];
    lens = '{4'd0, 4'd3, 4'd9};
    wins = '{8'd5, 8'd0, 8'd5};
    for (int i = 0; i < 3; i++) begin
      start_session(8'b0000_0101, lens[i], 1'b1, wins[i]);
      total++; if (busy !== 1'b0 || done !== 1'b1 || match_cnt !== 8'd0)
        $display("FAIL inv%0d_k1: got busy=%b done=%b cnt=%0d want 0 1 0", i, busy, done, match_cnt);
      else passed++;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0 || done !== 1'b0)
        $display("FAIL inv%0d_k2: got busy=%b done=%b want 0 0", i, busy, done);
      else passed++;
    end
  endtask

  task automatic test_abort();
    start_session(8'b0000_0001, 4'd1, 1'b1, 8'd10);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_seq = 1'b1;
      @(posedge clk); #1;
    end
    #1;
    total++; if (det_out !== 1'b1 || match_cnt !== 8'd2)
      $display("FAIL abort_pre: got det=%b cnt=%0d want 1 2", det_out, match_cnt);
    else passed++;
    rst = 1'b0;
    #1;
    total++; if ({det_out, busy, done, match_cnt} !== 11'd0)
      $display("FAIL abort_rst: got det=%b busy=%b done=%b cnt=%0d want all 0", det_out, busy, done, match_cnt);
    else passed++;
    in_valid = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_nodone: got done=%b busy=%b want 0 0", done, busy);
    else passed++;
    run_101("fresh", 1'b1, 5'b00101, 8'd2, 0);
  endtask

  task automatic test_saturation();
    cfg_pat = 8'b0000_0001; cfg_len = 4'd1; cfg_ovl = 1'b1;
    for (int s = 0; s < 2; s++) begin
      win4 = 4'd15; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      total++; if (busy4 !== 1'b1 || cnt4 !== 4'd0)
        $display("FAIL sat%0d_start: got busy=%b cnt=%0d want 1 0", s, busy4, cnt4);
      else passed++;
      for (int i = 0; i < 15; i++) begin
        valid4 = 1'b1; seq4 = 1'b1;
        #1;
        if (i == 0 || i == 14) begin
          total++; if (det4 !== 1'b1)
            $display("FAIL sat%0d_det bit%0d: got %b want 1", s, i + 1, det4);
          else passed++;
        end
        @(posedge clk); #1;
        valid4 = 1'b0;
      end
      total++; if (done4 !== 1'b1 || busy4 !== 1'b0 || cnt4 !== 4'd15)
        $display("FAIL sat%0d_done: got done=%b busy=%b cnt=%0d want 1 0 15", s, done4, busy4, cnt4);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    @(posedge clk); #1;
    test_overlap();
    test_back_to_back();
    test_gaps();
    test_invalid();
    test_abort();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Programmable serial pattern-detection controller that sequences a Mealy sequence detector over a bounded observation window. It latches a pattern configuration on a start request and runs the detector over a fixed number of valid input bits. Detection supports overlapping and non-overlapping modes, and matches are counted. It sits between a configuring host (start/done handshake) and a serial bit stream, generalising the fixed 101 detector to any pattern up to PAT_W bits.

## Interface
- PAT_W, 8, maximum pattern length in bits (2..15)
- CNT_W, 8, width of window length and match counter

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a session; sampled only in IDLE
- cfg_pat  in  PAT_W  pattern; cfg_pat[cfg_len-1] is the first bit received, cfg_pat[0] the last
- cfg_len  in  4  pattern length; valid range 1..PAT_W
- cfg_ovl  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_win  in  CNT_W  number of valid bits to observe; must be nonzero
- in_valid  in  1  qualifies in_seq this cycle
- in_seq  in  1  serial data bit
- det_out  out  1  Mealy match flag for the current bit (combinational)
- busy  out  1  session running
- done  out  1  one-cycle session-complete pulse
- match_cnt  out  CNT_W  matches in the current or last session; saturates at all-ones

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch cfg_pat, cfg_len, cfg_ovl and cfg_win.
  - Clear the history shift register, fill counter, bit counter and match_cnt.
  - Go to RUN. If cfg_len is 0 or greater than PAT_W, or cfg_win is 0, go to DONE instead; match_cnt stays 0.
- RUN, per cycle with in_valid=1:
  - hist <= {hist[PAT_W-2:0], in_seq}.
  - fill increments, saturating at PAT_W.
  - bit_cnt increments.
- RUN, in_valid=0: no state changes; in_seq is ignored.
- Match condition (RUN, in_valid=1): fill+1 >= len, and the low len bits of {hist, in_seq} equal the low len bits of the latched pattern.
  - det_out = 1 while the condition holds.
  - At the clock edge, match_cnt increments, saturating at 2^CNT_W-1.
- Non-overlap mode: a match sets fill to 0, so the next match needs len fresh bits.
- Overlap mode: fill continues normally after a match.
- When the accepted bit is bit number cfg_win, go to DONE, including when that bit also matches.
- DONE: done=1 for one cycle, then IDLE.
- match_cnt holds its value until the next accepted start.
- start while busy or in DONE is ignored.
- cfg_* changes after start has no effect on the running session.

## Timing
- Reset (rst=0), immediate and asynchronous:
  - state becomes IDLE.
  - det_out, busy, done and match_cnt are 0.
  - All internal registers are cleared.
- Reset mid-session aborts the session with no done pulse.
- start high in cycle k (state IDLE) -> busy=1 from cycle k+1.
- Invalid config -> done=1 in cycle k+1, and busy stays 0.
- det_out has zero latency: same cycle as the qualifying bit. match_cnt reflects that bit after the next rising edge.
- Last window bit accepted at edge e:
  - busy=0 and done=1 in the cycle after e.
  - done=0 and state is IDLE one cycle later.
  - A new start is accepted in that IDLE cycle.
- det_out is forced to 0 outside RUN, and in RUN whenever in_valid=0.

## Test plan
1. Reset: hold rst=0 for 12 time units with random inputs -> det_out, busy, done and match_cnt are all 0. Release rst; state is IDLE.
2. Overlap 101: cfg_pat=8'b101, cfg_len=3, cfg_ovl=1, cfg_win=5, stream 1,0,1,0,1 on consecutive valid cycles -> det_out=1 on bits 3 and 5 only, match_cnt=2, one done pulse the cycle after bit 5.
3. Non-overlap 101: same stimulus with cfg_ovl=0 -> det_out=1 on bit 3 only, match_cnt=1.
4. Valid gaps: scenario 2 with in_valid=0 cycles between bits and in_seq toggling during the gaps -> identical det_out bit positions, match_cnt=2, done after the 5th valid bit.
5. Invalid config: start with cfg_len=0, then with cfg_win=0 -> busy never asserts, done=1 the cycle after start, match_cnt=0.
6. Abort and saturation:
   - Assert rst=0 after 2 bits of a session -> all outputs 0 immediately. A new start runs a fresh session from bit 1.
   - Run with CNT_W=4, cfg_pat=1'b1, cfg_len=1, cfg_win=15, 15 ones -> match_cnt=15. A second session with cfg_win=15 and 15 ones also gives match_cnt=15.
